// File: rtl/mem_cfg_regfile_pkg.sv
// Shared types and constants for the memory-configuration register file.
package mem_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    REL  = 2'd3
  } state_t;

  // Bit positions inside the CTRL register
  localparam int EN_BIT   = 0;
  localparam int LOCK_BIT = 1;

  // CTRL sits directly after the port registers
  function automatic int ctrl_ofs(input int num_ports);
    return num_ports;
  endfunction

  // ERRCNT sits directly after CTRL
  function automatic int err_ofs(input int num_ports);
    return num_ports + 1;
  endfunction

endpackage

// File: rtl/mem_cfg_regfile_if.sv
// Memory-configuration bus: request side driven by the master, response by the slave.
interface mem_cfg_regfile_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              mem_sel_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_wr_rd_s;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_ack;
  logic              mem_err;

  modport master (
    output mem_sel_en, mem_addr, mem_wr_data, mem_wr_rd_s,
    input  mem_rd_data, mem_ack, mem_err
  );

  modport slave (
    input  mem_sel_en, mem_addr, mem_wr_data, mem_wr_rd_s,
    output mem_rd_data, mem_ack, mem_err
  );
endinterface

// File: rtl/mem_cfg_regfile_err_cnt.sv
// Saturating error counter with clear-on-read; an error in the clear cycle leaves 1.
module mem_cfg_err_cnt #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              clr,
  output logic [DATA_W-1:0] cnt
);

  // Count errors, clear on read, saturate at all-ones
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? DATA_W'(1) : '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + DATA_W'(1);
    end
  end

endmodule

// File: rtl/mem_cfg_regfile.sv
// Configuration register file on the switch memory bus: port address registers,
// CTRL (enable + sticky lock) and a clear-on-read error counter.
module mem_cfg_regfile
  import mem_cfg_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int NUM_PORTS = 4,
  parameter int ACK_LAT   = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  mem_cfg_regfile_if.slave            bus,
  output logic [NUM_PORTS*DATA_W-1:0] port_addr_o,
  output logic                        sw_enable_o,
  output logic                        cfg_locked_o
);

  localparam logic [ADDR_W-1:0] CTRL_A = ADDR_W'(ctrl_ofs(NUM_PORTS));
  localparam logic [ADDR_W-1:0] ERR_A  = ADDR_W'(err_ofs(NUM_PORTS));

  state_t            state;
  logic [2:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              wr_q;

  logic [DATA_W-1:0] port_q [NUM_PORTS];
  logic              en_q;
  logic              lock_q;

  logic              ack_q;
  logic              err_q;
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] err_cnt;

  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;
  logic              acc_wr;
  logic              acc_err;
  logic [DATA_W-1:0] acc_rd;
  logic              dup;
  logic              commit;

  // Decode the live bus request in IDLE (zero-latency case), else the latched one
  always_comb begin
    acc_addr = addr_q;
    acc_data = data_q;
    acc_wr   = wr_q;
    if (state == IDLE) begin
      acc_addr = bus.mem_addr;
      acc_data = bus.mem_wr_data;
      acc_wr   = bus.mem_wr_rd_s;
    end
  end

  // Legality check, duplicate-address compare and read mux for the current access
  always_comb begin
    dup     = 1'b0;
    acc_err = 1'b0;
    acc_rd  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if ((acc_data != '0) && (port_q[i] == acc_data) && (acc_addr != ADDR_W'(i)))
        dup = 1'b1;
    end
    if (acc_addr < CTRL_A) begin
      if (acc_wr) begin
        acc_err = lock_q || dup;
      end else begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (acc_addr == ADDR_W'(i)) acc_rd = port_q[i];
        end
      end
    end else if (acc_addr == CTRL_A) begin
      if (acc_wr) begin
        // Once locked, only writes that keep enable set are accepted
        acc_err = lock_q && !acc_data[EN_BIT];
      end else begin
        acc_rd[EN_BIT]   = en_q;
        acc_rd[LOCK_BIT] = lock_q;
      end
    end else if (acc_addr == ERR_A) begin
      if (acc_wr) acc_err = 1'b1;
      else        acc_rd  = err_cnt;
    end else begin
      acc_err = 1'b1;
    end
    if (acc_err) acc_rd = '0;
  end

  // Bus FSM; ack/err/rd_data are registered on entry to ACK
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      rd_q  <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      rd_q  <= '0;
      case (state)
        IDLE: begin
          if (bus.mem_sel_en) begin
            cnt_q <= 3'(ACK_LAT);
            if (ACK_LAT == 0) begin
              state <= ACK;
              ack_q <= 1'b1;
              err_q <= acc_err;
              rd_q  <= acc_rd;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!bus.mem_sel_en) begin
            state <= IDLE;
          end else if (cnt_q == 3'd1) begin
            state <= ACK;
            ack_q <= 1'b1;
            err_q <= acc_err;
            rd_q  <= acc_rd;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ACK:     state <= REL;
        REL:     if (!bus.mem_sel_en) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Capture the request once; address and data are not reset
  always_ff @(posedge clk) begin
    if ((state == IDLE) && bus.mem_sel_en) begin
      addr_q <= bus.mem_addr;
      data_q <= bus.mem_wr_data;
      wr_q   <= bus.mem_wr_rd_s;
    end
  end

  assign commit = (state == ACK);

  // Commit accepted writes at the end of the ACK cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) port_q[i] <= '0;
      en_q   <= 1'b0;
      lock_q <= 1'b0;
    end else if (commit && wr_q && !err_q) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (addr_q == ADDR_W'(i)) port_q[i] <= data_q;
      end
      if (addr_q == CTRL_A) begin
        en_q   <= data_q[EN_BIT];
        lock_q <= lock_q | data_q[LOCK_BIT];
      end
    end
  end

  mem_cfg_err_cnt #(.DATA_W(DATA_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (commit && err_q),
    .clr   (commit && !err_q && !wr_q && (addr_q == ERR_A)),
    .cnt   (err_cnt)
  );

  // Flatten port registers onto the datapath bus
  always_comb begin
    port_addr_o = '0;
    for (int i = 0; i < NUM_PORTS; i++) port_addr_o[i*DATA_W +: DATA_W] = port_q[i];
  end

  assign sw_enable_o     = en_q;
  assign cfg_locked_o    = lock_q;
  assign bus.mem_ack     = ack_q;
  assign bus.mem_err     = err_q;
  assign bus.mem_rd_data = rd_q;

endmodule

// File: tb/tb_mem_cfg_regfile.sv
// Bench: two instances (ack latency 0 and 3) driven from shared stimulus and
// compared against an abstract register-map model.
module tb_mem_cfg_regfile;
  localparam int NP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] sel_v = 2'b00;
  logic [7:0] addr_v = '0;
  logic [7:0] wdata_v = '0;
  logic       wr_v = 1'b0;

  logic        ack_w [2];
  logic        err_w [2];
  logic [7:0]  rd_w  [2];
  logic [31:0] port_w [2];
  logic        en_w [2];
  logic        lk_w [2];

  mem_cfg_regfile_if #(.DATA_W(8), .ADDR_W(8)) if0 ();
  mem_cfg_regfile_if #(.DATA_W(8), .ADDR_W(8)) if3 ();

  assign if0.mem_sel_en  = sel_v[0];
  assign if0.mem_addr    = addr_v;
  assign if0.mem_wr_data = wdata_v;
  assign if0.mem_wr_rd_s = wr_v;
  assign if3.mem_sel_en  = sel_v[1];
  assign if3.mem_addr    = addr_v;
  assign if3.mem_wr_data = wdata_v;
  assign if3.mem_wr_rd_s = wr_v;

  assign ack_w[0] = if0.mem_ack;
  assign err_w[0] = if0.mem_err;
  assign rd_w[0]  = if0.mem_rd_data;
  assign ack_w[1] = if3.mem_ack;
  assign err_w[1] = if3.mem_err;
  assign rd_w[1]  = if3.mem_rd_data;

  mem_cfg_regfile #(.DATA_W(8), .ADDR_W(8), .NUM_PORTS(NP), .ACK_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0),
    .port_addr_o(port_w[0]), .sw_enable_o(en_w[0]), .cfg_locked_o(lk_w[0])
  );

  mem_cfg_regfile #(.DATA_W(8), .ADDR_W(8), .NUM_PORTS(NP), .ACK_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3),
    .port_addr_o(port_w[1]), .sw_enable_o(en_w[1]), .cfg_locked_o(lk_w[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, one copy per instance
  logic [7:0] m_port [2][NP];
  logic       m_en [2];
  logic       m_lk [2];
  int         m_cnt [2];

  logic [7:0] last_rd [2];
  logic       last_er [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < NP; j++) m_port[k][j] = '0;
      m_en[k] = 1'b0;
      m_lk[k] = 1'b0;
      m_cnt[k] = 0;
    end
  endtask

  // Register-map rules applied to one access
  task automatic model_step(input int k, input bit wr, input int ofs, input logic [7:0] d,
                            output logic e, output logic [7:0] r);
    e = 1'b0;
    r = '0;
    if (ofs > NP + 1) begin
      e = 1'b1;
    end else if (ofs == NP + 1) begin
      if (wr) e = 1'b1;
      else begin r = 8'(m_cnt[k]); m_cnt[k] = 0; end
    end else if (ofs == NP) begin
      if (!wr) r = {6'b0, m_lk[k], m_en[k]};
      else if (m_lk[k] && !d[0]) e = 1'b1;
      else begin m_en[k] = d[0]; m_lk[k] = m_lk[k] | d[1]; end
    end else begin
      if (!wr) r = m_port[k][ofs];
      else if (m_lk[k]) e = 1'b1;
      else begin
        if (d != 0)
          for (int j = 0; j < NP; j++)
            if (j != ofs && m_port[k][j] == d) e = 1'b1;
        if (!e) m_port[k][ofs] = d;
      end
    end
    if (e) m_cnt[k] = (m_cnt[k] < 255) ? m_cnt[k] + 1 : 255;
  endtask

  task automatic check_outs(input int k);
    logic [31:0] exp_v;
    for (int j = 0; j < NP; j++) exp_v[j*8 +: 8] = m_port[k][j];
    chk($sformatf("port_addr_o[%0d]", k), port_w[k], exp_v);
    chk($sformatf("sw_enable_o[%0d]", k), 32'(en_w[k]), 32'(m_en[k]));
    chk($sformatf("cfg_locked_o[%0d]", k), 32'(lk_w[k]), 32'(m_lk[k]));
  endtask

  // One bus access on the instances in mask, holding sel_en for 'hold' cycles
  task automatic access(input bit [1:0] mask, input bit wr, input int ofs, input logic [7:0] d,
                        input int hold, input bit expect_ack);
    int nack [2];
    int lat [2];
    logic [7:0] rd [2];
    logic er [2];
    logic e_m;
    logic [7:0] r_m;
    for (int k = 0; k < 2; k++) begin nack[k] = 0; lat[k] = 0; rd[k] = '0; er[k] = 1'b0; end
    addr_v = 8'(ofs);
    wdata_v = d;
    wr_v = wr;
    sel_v = mask;
    for (int c = 1; c <= hold + 3; c++) begin
      if (c == hold + 1) sel_v = 2'b00;
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (mask[k] && ack_w[k]) begin
          nack[k]++;
          if (nack[k] == 1) begin lat[k] = c; rd[k] = rd_w[k]; er[k] = err_w[k]; end
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (mask[k]) begin
        if (expect_ack) begin
          model_step(k, wr, ofs, d, e_m, r_m);
          chk($sformatf("latency[%0d]", k), 32'(lat[k]), (k == 0) ? 32'd1 : 32'd4);
          chk($sformatf("ack_count[%0d]", k), 32'(nack[k]), 32'd1);
          chk($sformatf("mem_err[%0d] ofs%0d", k, ofs), 32'(er[k]), 32'(e_m));
          chk($sformatf("rd_data[%0d] ofs%0d", k, ofs), 32'(rd[k]), 32'(r_m));
          last_rd[k] = rd[k];
          last_er[k] = er[k];
        end else begin
          chk($sformatf("no_ack[%0d]", k), 32'(nack[k]), 32'd0);
        end
        check_outs(k);
      end
    end
  endtask

  task automatic do_reset();
    sel_v = 2'b00;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_ack[%0d]", k), 32'(ack_w[k]), 32'd0);
      chk($sformatf("rst_err[%0d]", k), 32'(err_w[k]), 32'd0);
      chk($sformatf("rst_rd[%0d]", k), 32'(rd_w[k]), 32'd0);
      check_outs(k);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nack;
    logic [7:0] d;
    int ofs;
    bit wr;

    do_reset();

    // Write then read PORT2
    access(2'b11, 1'b1, 2, 8'h2A, 6, 1'b1);
    access(2'b11, 1'b0, 2, 8'h00, 6, 1'b1);
    chk("t1_rd_port2", 32'(last_rd[0]), 32'h2A);
    chk("t1_port_addr_o", 32'(port_w[0][23:16]), 32'h2A);

    // Long hold gives one ack; dropping during WAIT aborts the write
    access(2'b11, 1'b0, NP, 8'h00, 10, 1'b1);
    access(2'b10, 1'b1, 0, 8'h77, 2, 1'b0);
    access(2'b11, 1'b0, 0, 8'h00, 6, 1'b1);
    chk("t2_abort_no_write", 32'(last_rd[1]), 32'h00);

    // Duplicate rejection
    access(2'b11, 1'b1, 0, 8'h11, 6, 1'b1);
    access(2'b11, 1'b1, 1, 8'h11, 6, 1'b1);
    chk("t3_dup_err", 32'(last_er[1]), 32'd1);
    access(2'b11, 1'b0, 1, 8'h00, 6, 1'b1);
    chk("t3_port1_kept", 32'(last_rd[0]), 32'h00);
    access(2'b11, 1'b1, 1, 8'h00, 6, 1'b1);
    chk("t3_zero_ok", 32'(last_er[0]), 32'd0);

    // Randomized traffic with occasional lock
    do_reset();
    for (int n = 0; n < 200; n++) begin
      ofs = $urandom_range(0, 7);
      wr = 1'($urandom_range(0, 1));
      if (ofs == NP) d = ($urandom_range(0, 15) == 0) ? 8'h03 : 8'($urandom_range(0, 1));
      else if ($urandom_range(0, 7) == 0) d = 8'($urandom);
      else d = 8'($urandom_range(0, 7));
      access(2'b11, wr, ofs, d, 6, 1'b1);
    end

    // Lock behaviour
    do_reset();
    access(2'b11, 1'b1, NP, 8'h03, 6, 1'b1);
    chk("t4_enable", 32'(en_w[0]), 32'd1);
    chk("t4_locked", 32'(lk_w[1]), 32'd1);
    access(2'b11, 1'b1, 3, 8'h05, 6, 1'b1);
    chk("t4_port_locked_err", 32'(last_er[0]), 32'd1);
    access(2'b11, 1'b1, NP, 8'h01, 6, 1'b1);
    chk("t4_lock_sticky", 32'(lk_w[0]), 32'd1);

    // Error counting, clear-on-read and saturation
    do_reset();
    access(2'b11, 1'b0, 6, 8'h00, 6, 1'b1);
    chk("t5_illegal_err", 32'(last_er[0]), 32'd1);
    chk("t5_illegal_rd", 32'(last_rd[0]), 32'd0);
    access(2'b11, 1'b1, NP + 1, 8'h5A, 6, 1'b1);
    chk("t5_wr_errcnt_err", 32'(last_er[1]), 32'd1);
    access(2'b11, 1'b0, NP + 1, 8'h00, 6, 1'b1);
    chk("t5_errcnt_2", 32'(last_rd[0]), 32'h02);
    access(2'b11, 1'b0, NP + 1, 8'h00, 6, 1'b1);
    chk("t5_errcnt_cleared", 32'(last_rd[1]), 32'h00);
    for (int n = 0; n < 300; n++)
      access(2'b11, 1'($urandom_range(0, 1)), $urandom_range(NP + 2, 255), 8'($urandom), 6, 1'b1);
    access(2'b11, 1'b0, NP + 1, 8'h00, 6, 1'b1);
    chk("t5_errcnt_sat", 32'(last_rd[0]), 32'hFF);

    // Reset during WAIT drops the access
    access(2'b11, 1'b1, 1, 8'h33, 6, 1'b1);
    addr_v = 8'd2;
    wdata_v = 8'h55;
    wr_v = 1'b1;
    sel_v = 2'b10;
    nack = 0;
    repeat (2) begin @(posedge clk); #1; if (ack_w[1]) nack++; end
    rst_n = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (ack_w[1]) nack++; end
    sel_v = 2'b00;
    rst_n = 1'b1;
    model_reset();
    chk("t6_no_ack", 32'(nack), 32'd0);
    for (int k = 0; k < 2; k++) check_outs(k);
    for (int o = 0; o <= NP + 1; o++) access(2'b11, 1'b0, o, 8'h00, 6, 1'b1);
    access(2'b11, 1'b0, 1, 8'h00, 6, 1'b1);
    chk("t6_port1_cleared", 32'(last_rd[1]), 32'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
